// File: rtl/div_if.sv
// div_if: start/operand request and result/status bundle between control unit and divider
interface div_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             div_zero;
  modport master (output start, is_signed, dividend, divisor, input q, r, busy, done, div_zero);
  modport slave  (input start, is_signed, dividend, divisor, output q, r, busy, done, div_zero);
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU (quotient to LO, remainder to HI)
module div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic clk,
  input  logic reset,
  div_if.slave div_io
);
  localparam int CW = $clog2(ITER);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;
  state_e           state_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, q_q, r_q;
  logic [CW-1:0]    cnt_q;
  logic             qneg_q, rneg_q, busy_q, done_q, dz_q;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_d, quo_d, dvd_abs, dvs_abs, q_fix, r_fix;
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    rem_d   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    dvd_abs = (div_io.is_signed && div_io.dividend[WIDTH-1]) ? -div_io.dividend : div_io.dividend;
    dvs_abs = (div_io.is_signed && div_io.divisor[WIDTH-1]) ? -div_io.divisor : div_io.divisor;
    // a zero divisor leaves |dividend| in rem, so only the quotient needs forcing
    q_fix   = (dvs_q == '0) ? '1 : qneg_q ? -quo_q : quo_q;
    r_fix   = rneg_q ? -rem_q : rem_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (div_io.start) begin
          quo_q   <= dvd_abs;
          dvs_q   <= dvs_abs;
          rem_q   <= '0;
          cnt_q   <= '0;
          qneg_q  <= div_io.is_signed & (div_io.dividend[WIDTH-1] ^ div_io.divisor[WIDTH-1]);
          rneg_q  <= div_io.is_signed & div_io.dividend[WIDTH-1];
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(ITER - 1)) state_q <= FINISH;
        end
        FINISH: begin
          q_q     <= q_fix;
          r_q     <= r_fix;
          dz_q    <= (dvs_q == '0);
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign div_io.q        = q_q;
  assign div_io.r        = r_q;
  assign div_io.busy     = busy_q;
  assign div_io.done     = done_q;
  assign div_io.div_zero = dz_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random DIV/DIVU checks of div_unit against an arithmetic reference
module tb_div_unit;
  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  div_if bus ();
  div_unit dut (.clk(clk), .reset(reset), .div_io(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eq, output logic [31:0] er, output logic edz);
    longint x, y;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF; er = a; edz = 1'b1;
    end else if (s) begin
      x = longint'($signed(a)); y = longint'($signed(b));
      eq = 32'(x / y); er = 32'(x % y); edz = 1'b0;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0;
    end
  endfunction

  task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = s; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0; bus.is_signed = ~s; bus.dividend = $urandom; bus.divisor = $urandom;
  endtask

  task automatic wait_done(output int bc, output bit got);
    bc = 0; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (bus.done) got = 1'b1;
      else begin
        if (bus.busy) bc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic finish_check(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b,
                              input int bc, input bit got, input int exp_bc);
    logic [31:0] eq, er;
    logic        edz;
    model(s, a, b, eq, er, edz);
    check({tag, "_busy_len"}, bc, exp_bc);
    check({tag, "_done"}, got, 1);
    check({tag, "_busy_at_done"}, bus.busy, 0);
    check({tag, "_q"}, bus.q, eq);
    check({tag, "_r"}, bus.r, er);
    check({tag, "_dz"}, bus.div_zero, edz);
  endtask

  task automatic run(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b);
    int bc;
    bit got;
    launch(s, a, b);
    wait_done(bc, got);
    finish_check(tag, s, a, b, bc, got, 33);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, bus.done, 0);
  endtask

  initial begin
    int          bc, dcount;
    bit          got, s;
    logic [31:0] a, b;
    reset = 1'b1;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_q", bus.q, 0);
    check("rst_r", bus.r, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dz", bus.div_zero, 0);
    reset = 1'b0;

    run("divu_100_7", 1'b0, 32'd100, 32'd7);
    run("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'h10);
    run("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    run("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run("div_by0", 1'b1, 32'h0000_1234, 32'd0);
    run("divu_9_3", 1'b0, 32'd9, 32'd3);
    run("div_neg_by0", 1'b1, 32'h8000_0001, 32'd0);

    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 4))
        0: b = 32'($urandom);
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: b = 32'($urandom) >> $urandom_range(1, 31);
        default: b = 32'd0;
      endcase
      run("rand", s, a, b);
    end

    // a second start 5 cycles into busy must be dropped
    launch(1'b0, 32'd1000, 32'd33);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b1; bus.dividend = 32'd77; bus.divisor = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(bc, got);
    finish_check("ignore", 1'b0, 32'd1000, 32'd33, bc, got, 28);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcount++;
    end
    check("ignore_no_second_op", dcount, 0);

    // start asserted in the done cycle is accepted
    launch(1'b1, 32'hFFFF_FC18, 32'd7);
    wait_done(bc, got);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd123457; bus.divisor = 32'd10;
    finish_check("back1", 1'b1, 32'hFFFF_FC18, 32'd7, bc, got, 33);
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = $urandom;
    check("back_busy_rise", bus.busy, 1);
    check("back_done_low", bus.done, 0);
    wait_done(bc, got);
    finish_check("back2", 1'b0, 32'd123457, 32'd10, bc, got, 33);

    // reset in busy cycle 10 aborts without a done pulse
    launch(1'b0, 32'd999, 32'd4);
    repeat (9) @(negedge clk);
    check("abort_busy_before", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_q", bus.q, 0);
    check("abort_r", bus.r, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_dz", bus.div_zero, 0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcount++;
    end
    check("abort_no_done", dcount, 0);
    run("divu_50_5", 1'b0, 32'd50, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
